bank_write_arbiter: RTL and testbench

//  Per-bank write-port arbiter for the BANK_COUNT-bank tile buffer. Shares each bank between the local

---
 rtl/bank_write_arbiter_if.sv | 34 +++
 rtl/bank_write_arbiter.sv | 83 ++++++++
 tb/tb_bank_write_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/bank_write_arbiter_if.sv
// rtl/bank_write_arbiter_if.sv - per-bank local/neighbor write requests and bank write-port outputs
interface bank_write_arbiter_if #(
  parameter int BANK_COUNT = 32,
  parameter int RW         = 8
);
  logic [BANK_COUNT-1:0][RW-1:0] local_row;
  logic [BANK_COUNT-1:0][RW-1:0] local_column;
  logic [BANK_COUNT-1:0][7:0]    local_data;
  logic [BANK_COUNT-1:0]         local_we;
  logic [BANK_COUNT-1:0]         local_ready;
  logic [BANK_COUNT-1:0][RW-1:0] neighbor_row;
  logic [BANK_COUNT-1:0][RW-1:0] neighbor_column;
  logic [BANK_COUNT-1:0][7:0]    neighbor_data;
  logic [BANK_COUNT-1:0]         neighbor_we;
  logic                          neighbor_stall;
  logic [BANK_COUNT-1:0][RW-1:0] bank_row;
  logic [BANK_COUNT-1:0][RW-1:0] bank_column;
  logic [BANK_COUNT-1:0][7:0]    bank_data;
  logic [BANK_COUNT-1:0]         bank_we;
  logic                          busy;
  logic                          overflow;

  modport master (
    output local_row, local_column, local_data, local_we,
    output neighbor_row, neighbor_column, neighbor_data, neighbor_we,
    input  local_ready, neighbor_stall, bank_row, bank_column, bank_data, bank_we, busy, overflow
  );

  modport slave (
    input  local_row, local_column, local_data, local_we,
    input  neighbor_row, neighbor_column, neighbor_data, neighbor_we,
    output local_ready, neighbor_stall, bank_row, bank_column, bank_data, bank_we, busy, overflow
  );
endinterface

// File: rtl/bank_write_arbiter.sv
// rtl/bank_write_arbiter.sv - per-bank write-port arbiter: local priority, 2-deep neighbor FIFO, starvation guard
module bank_write_arbiter #(
  parameter int BANK_COUNT   = 32,
  parameter int TILE_SIZE    = 256,
  parameter int STARVE_LIMIT = 4
) (
  input logic                clk,
  input logic                reset_n,
  bank_write_arbiter_if.slave bus
);
  localparam int RW = $clog2(TILE_SIZE);
  localparam int EW = 2 * RW + 8;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [EW-1:0]         fifo_mem [BANK_COUNT][2];
  logic [BANK_COUNT-1:0] rd_ptr;
  logic [1:0]            count    [BANK_COUNT];
  logic [SW-1:0]         starve   [BANK_COUNT];

  logic [BANK_COUNT-1:0] pending;
  logic [BANK_COUNT-1:0] grant_n;
  logic [BANK_COUNT-1:0] grant_l;
  logic [BANK_COUNT-1:0] push_ok;
  logic [EW-1:0]         head     [BANK_COUNT];

  // Decisions use registered FIFO/starve state only, so local_ready never depends on neighbor_we.
  always_comb begin
    for (int b = 0; b < BANK_COUNT; b++) begin
      pending[b] = (count[b] != 2'd0);
      grant_n[b] = pending[b] & (!bus.local_we[b] | (starve[b] >= SW'(STARVE_LIMIT)));
      grant_l[b] = bus.local_we[b] & !grant_n[b];
      push_ok[b] = bus.neighbor_we[b] & ((count[b] != 2'd2) | grant_n[b]);
      head[b]    = fifo_mem[b][rd_ptr[b]];
    end
  end

  assign bus.local_ready    = ~grant_n;
  assign bus.neighbor_stall = |pending;
  assign bus.busy           = |pending;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < BANK_COUNT; b++) begin
        count[b]       <= 2'd0;
        starve[b]      <= '0;
        fifo_mem[b][0] <= '0;
        fifo_mem[b][1] <= '0;
      end
      rd_ptr          <= '0;
      bus.bank_row    <= '0;
      bus.bank_column <= '0;
      bus.bank_data   <= '0;
      bus.bank_we     <= '0;
      bus.overflow    <= 1'b0;
    end else begin
      for (int b = 0; b < BANK_COUNT; b++) begin
        bus.bank_we[b] <= grant_n[b] | grant_l[b];
        if (grant_n[b]) begin
          {bus.bank_row[b], bus.bank_column[b], bus.bank_data[b]} <= head[b];
          rd_ptr[b] <= ~rd_ptr[b];
        end else if (grant_l[b]) begin
          {bus.bank_row[b], bus.bank_column[b], bus.bank_data[b]} <=
            {bus.local_row[b], bus.local_column[b], bus.local_data[b]};
        end

        // Tail slot is rd_ptr+count mod 2; when full and popping it is the slot being freed.
        if (push_ok[b]) begin
          fifo_mem[b][rd_ptr[b] ^ count[b][0]] <=
            {bus.neighbor_row[b], bus.neighbor_column[b], bus.neighbor_data[b]};
        end else if (bus.neighbor_we[b]) begin
          bus.overflow <= 1'b1;
        end
        count[b] <= count[b] + {1'b0, push_ok[b]} - {1'b0, grant_n[b]};

        if (grant_n[b] || !pending[b]) begin
          starve[b] <= '0;
        end else if (grant_l[b] && (starve[b] != SW'(STARVE_LIMIT))) begin
          starve[b] <= starve[b] + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_bank_write_arbiter.sv
// tb/tb_bank_write_arbiter.sv - directed self-checking bench for bank_write_arbiter
module tb_bank_write_arbiter;
  localparam int B  = 32;
  localparam int RW = 8;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  bank_write_arbiter_if #(.BANK_COUNT(B), .RW(RW)) bus ();

  bank_write_arbiter #(.BANK_COUNT(B), .TILE_SIZE(256), .STARVE_LIMIT(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] log_q[$];
  logic        seen;

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b1;
    bus.local_row       = '0;
    bus.local_column    = '0;
    bus.local_data      = '0;
    bus.local_we        = '0;
    bus.neighbor_row    = '0;
    bus.neighbor_column = '0;
    bus.neighbor_data   = '0;
    bus.neighbor_we     = '0;
    #1 reset_n = 1'b0;
    #1;
    check("rst_bank_we",  bus.bank_we, 32'h0);
    check("rst_overflow", {31'h0, bus.overflow}, 32'h0);
    check("rst_busy",     {31'h0, bus.busy}, 32'h0);
    check("rst_stall",    {31'h0, bus.neighbor_stall}, 32'h0);
    check("rst_ready",    bus.local_ready, 32'hFFFF_FFFF);
    step();
    step();
    reset_n = 1'b1;
    step();

    // T1 local only
    bus.local_we[5] = 1'b1; bus.local_row[5] = 8'd1; bus.local_column[5] = 8'd2; bus.local_data[5] = 8'hAA;
    check("t1_ready", {31'h0, bus.local_ready[5]}, 32'h1);
    step();
    bus.local_we[5] = 1'b0;
    check("t1_we",   bus.bank_we, 32'h0000_0020);
    check("t1_row",  {24'h0, bus.bank_row[5]}, 32'h1);
    check("t1_col",  {24'h0, bus.bank_column[5]}, 32'h2);
    check("t1_data", {24'h0, bus.bank_data[5]}, 32'hAA);
    check("t1_ready_after", {31'h0, bus.local_ready[5]}, 32'h1);
    step();
    check("t1_we_drop",  bus.bank_we, 32'h0);
    check("t1_data_hold", {24'h0, bus.bank_data[5]}, 32'hAA);

    // T2 neighbor only
    bus.neighbor_we[3] = 1'b1; bus.neighbor_data[3] = 8'h11; bus.neighbor_row[3] = 8'd3; bus.neighbor_column[3] = 8'd4;
    step();
    bus.neighbor_we[3] = 1'b0;
    check("t2_stall_t1", {31'h0, bus.neighbor_stall}, 32'h1);
    check("t2_busy_t1",  {31'h0, bus.busy}, 32'h1);
    check("t2_we_t1",    bus.bank_we, 32'h0);
    step();
    check("t2_we_t2",    bus.bank_we, 32'h0000_0008);
    check("t2_data",     {24'h0, bus.bank_data[3]}, 32'h11);
    check("t2_col",      {24'h0, bus.bank_column[3]}, 32'h4);
    check("t2_stall_t2", {31'h0, bus.neighbor_stall}, 32'h0);
    step();

    // T3 starvation on bank 7
    bus.local_we[7] = 1'b1; bus.local_data[7] = 8'h70;
    bus.neighbor_we[7] = 1'b1; bus.neighbor_data[7] = 8'h55;
    step();
    bus.neighbor_we[7] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("t3_local_data_%0d", k), {23'h0, bus.bank_we[7], bus.bank_data[7]}, 32'h100 | (32'h70 + k - 1));
      check($sformatf("t3_ready_%0d", k), {31'h0, bus.local_ready[7]}, 32'h1);
      bus.local_data[7] = 8'(8'h70 + k);
      step();
    end
    check("t3_local_data_5", {24'h0, bus.bank_data[7]}, 32'h74);
    check("t3_ready_5", {31'h0, bus.local_ready[7]}, 32'h0);
    bus.local_data[7] = 8'h75;
    step();
    check("t3_neighbor_write", {23'h0, bus.bank_we[7], bus.bank_data[7]}, 32'h155);
    check("t3_ready_6", {31'h0, bus.local_ready[7]}, 32'h1);
    step();
    check("t3_local_resume", {23'h0, bus.bank_we[7], bus.bank_data[7]}, 32'h175);
    bus.local_we[7] = 1'b0;
    step();

    // T6 independence
    bus.local_we[0] = 1'b1; bus.local_data[0] = 8'h0D;
    bus.neighbor_we[1] = 1'b1; bus.neighbor_data[1] = 8'h1E;
    check("t6_ready0_t0", {31'h0, bus.local_ready[0]}, 32'h1);
    step();
    bus.local_we[0] = 1'b0; bus.neighbor_we[1] = 1'b0;
    check("t6_we_t1", bus.bank_we, 32'h0000_0001);
    check("t6_ready0_t1", {31'h0, bus.local_ready[0]}, 32'h1);
    step();
    check("t6_we_t2", bus.bank_we, 32'h0000_0002);
    check("t6_data1", {24'h0, bus.bank_data[1]}, 32'h1E);
    check("t6_ready0_t2", {31'h0, bus.local_ready[0]}, 32'h1);
    step();

    // T4 overflow on bank 2 with local held
    bus.local_we[2] = 1'b1; bus.local_data[2] = 8'h20;
    bus.neighbor_we[2] = 1'b1; bus.neighbor_data[2] = 8'hA1;
    check("t4_no_overflow_t0", {31'h0, bus.overflow}, 32'h0);
    step();
    bus.neighbor_data[2] = 8'hA2;
    step();
    bus.neighbor_data[2] = 8'hA3;
    check("t4_no_overflow_t2", {31'h0, bus.overflow}, 32'h0);
    step();
    bus.neighbor_we[2] = 1'b0;
    check("t4_overflow", {31'h0, bus.overflow}, 32'h1);
    log_q.delete();
    for (int c = 3; c <= 14; c++) begin
      if (bus.bank_we[2] && bus.bank_data[2] != 8'h20) log_q.push_back({8'(c), bus.bank_data[2]});
      step();
    end
    check("t4_written_count", log_q.size(), 32'd2);
    if (log_q.size() >= 2) begin
      check("t4_first",  {16'h0, log_q[0]}, {16'h0, 8'd6, 8'hA1});
      check("t4_second", {16'h0, log_q[1]}, {16'h0, 8'd11, 8'hA2});
    end
    bus.local_we[2] = 1'b0;
    step();
    check("t4_drained", {31'h0, bus.busy}, 32'h0);
    check("t4_sticky",  {31'h0, bus.overflow}, 32'h1);

    // T5 reset with two entries pending in bank 9
    bus.local_we[9] = 1'b1; bus.local_data[9] = 8'h90;
    bus.neighbor_we[9] = 1'b1; bus.neighbor_data[9] = 8'h91;
    step();
    bus.neighbor_data[9] = 8'h92;
    step();
    bus.neighbor_we[9] = 1'b0;
    check("t5_busy_pre", {31'h0, bus.busy}, 32'h1);
    bus.local_we[9] = 1'b0;
    reset_n = 1'b0;
    #1;
    check("t5_we",       bus.bank_we, 32'h0);
    check("t5_data",     {24'h0, bus.bank_data[9]}, 32'h0);
    check("t5_stall",    {31'h0, bus.neighbor_stall}, 32'h0);
    check("t5_busy",     {31'h0, bus.busy}, 32'h0);
    check("t5_overflow", {31'h0, bus.overflow}, 32'h0);
    step();
    reset_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      seen = seen | bus.bank_we[9];
      step();
    end
    check("t5_no_write", {31'h0, seen}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
